// File: rtl/bot_sysreg_gen.sv
// Robot system-register generator: every UPDATE_DIV cycles it samples the
// motor command, advances heading/position/odometers and publishes a new
// register set, announced with a one-cycle upd_sysregs pulse.
//
// Ports:
//   sysclk      - system clock, all state on the rising edge
//   sysreset    - asynchronous active-low reset
//   run         - 1 = period counter advances, 0 = counter holds
//   MotCtl      - [7] left dir, [6:4] left speed, [3] right dir, [2:0] right speed
//   locx, locy  - committed bot coordinates
//   botinfo     - [2:0] heading, [3] blocked, [4] moved
//   sensors     - [0] x==0, [1] x==255, [2] y==0, [3] y==255
//   lmdist      - left-wheel odometer (mod 256)
//   rmdist      - right-wheel odometer (mod 256)
//   upd_sysregs - one-cycle pulse: new register set valid
module bot_sysreg_gen #(
  parameter int unsigned UPDATE_DIV = 5000000,
  parameter logic [7:0]  INIT_X     = 8'd128,
  parameter logic [7:0]  INIT_Y     = 8'd128
) (
  input  logic       sysclk,
  input  logic       sysreset,
  input  logic       run,
  input  logic [7:0] MotCtl,
  output logic [7:0] locx,
  output logic [7:0] locy,
  output logic [7:0] botinfo,
  output logic [7:0] sensors,
  output logic [7:0] lmdist,
  output logic [7:0] rmdist,
  output logic       upd_sysregs
);

  localparam int unsigned CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_DIV - 1);

  typedef enum logic [1:0] {
    S_COUNT  = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2,
    S_NOTIFY = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  logic calc_c;
  logic commit_c;
  logic notify_c;

  // Staged results, captured in CALC and published in COMMIT
  logic [7:0] stg_x;
  logic [7:0] stg_y;
  logic [2:0] stg_hdg;
  logic       stg_blk;
  logic       stg_mov;
  logic [7:0] stg_lm;
  logic [7:0] stg_rm;

  // Combinational next-value computation
  logic [2:0] heading;
  logic       ldir;
  logic       rdir;
  logic [2:0] lspd;
  logic [2:0] rspd;
  logic       lnz;
  logic       rnz;
  logic       xi;
  logic       xd;
  logic       yi;
  logic       yd;
  logic       mxi;
  logic       mxd;
  logic       myi;
  logic       myd;
  logic [7:0] nx_c;
  logic [7:0] ny_c;
  logic [2:0] nh_c;
  logic       nblk_c;
  logic       nmov_c;

  assign heading  = botinfo[2:0];
  assign ldir     = MotCtl[7];
  assign lspd     = MotCtl[6:4];
  assign rdir     = MotCtl[3];
  assign rspd     = MotCtl[2:0];
  assign lnz      = (lspd != 3'd0);
  assign rnz      = (rspd != 3'd0);
  assign cnt_last = (cnt == CNT_LAST);

  // Period counter: free-running through CALC/COMMIT/NOTIFY, gated only by run
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state <= S_COUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_COUNT:  if (run && cnt_last) state_nxt = S_CALC;
      S_CALC:   state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_NOTIFY;
      S_NOTIFY: state_nxt = S_COUNT;
      default:  state_nxt = S_COUNT;
    endcase
  end

  // FSM decoded strobes
  always_comb begin
    calc_c   = 1'b0;
    commit_c = 1'b0;
    notify_c = 1'b0;
    case (state)
      S_CALC:   calc_c   = 1'b1;
      S_COMMIT: commit_c = 1'b1;
      S_NOTIFY: notify_c = 1'b1;
      default:  ;
    endcase
  end

  // Unit step of the current heading, split into inc/dec flags per axis
  always_comb begin
    xi = 1'b0;
    xd = 1'b0;
    yi = 1'b0;
    yd = 1'b0;
    case (heading)
      3'd0: yi = 1'b1;
      3'd1: begin xi = 1'b1; yi = 1'b1; end
      3'd2: xi = 1'b1;
      3'd3: begin xi = 1'b1; yd = 1'b1; end
      3'd4: yd = 1'b1;
      3'd5: begin xd = 1'b1; yd = 1'b1; end
      3'd6: xd = 1'b1;
      default: begin xd = 1'b1; yi = 1'b1; end
    endcase
  end

  // Motion rules: translate when both wheels agree, otherwise rotate
  always_comb begin
    nx_c   = locx;
    ny_c   = locy;
    nh_c   = heading;
    nblk_c = 1'b0;
    mxi    = 1'b0;
    mxd    = 1'b0;
    myi    = 1'b0;
    myd    = 1'b0;
    if (lnz && rnz && (ldir == rdir)) begin
      // Reverse drive swaps the sense of each axis step
      mxi = ldir ? xd : xi;
      mxd = ldir ? xi : xd;
      myi = ldir ? yd : yi;
      myd = ldir ? yi : yd;
    end else if (lnz && rnz) begin
      nh_c = ldir ? 3'(heading - 3'd1) : 3'(heading + 3'd1);
    end else if (lnz) begin
      nh_c = ldir ? 3'(heading - 3'd1) : 3'(heading + 3'd1);
    end else if (rnz) begin
      nh_c = rdir ? 3'(heading + 3'd1) : 3'(heading - 3'd1);
    end
    // Each axis saturates independently; a refused step flags blocked
    if (mxi) begin
      if (locx == 8'hFF) nblk_c = 1'b1;
      else               nx_c   = 8'(locx + 8'd1);
    end
    if (mxd) begin
      if (locx == 8'h00) nblk_c = 1'b1;
      else               nx_c   = 8'(locx - 8'd1);
    end
    if (myi) begin
      if (locy == 8'hFF) nblk_c = 1'b1;
      else               ny_c   = 8'(locy + 8'd1);
    end
    if (myd) begin
      if (locy == 8'h00) nblk_c = 1'b1;
      else               ny_c   = 8'(locy - 8'd1);
    end
    nmov_c = (nx_c != locx) || (ny_c != locy);
  end

  // CALC: single sample of MotCtl into the staging registers
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      stg_x   <= INIT_X;
      stg_y   <= INIT_Y;
      stg_hdg <= 3'd0;
      stg_blk <= 1'b0;
      stg_mov <= 1'b0;
      stg_lm  <= 8'd0;
      stg_rm  <= 8'd0;
    end else if (calc_c) begin
      stg_x   <= nx_c;
      stg_y   <= ny_c;
      stg_hdg <= nh_c;
      stg_blk <= nblk_c;
      stg_mov <= nmov_c;
      stg_lm  <= 8'(lmdist + {5'd0, lspd});
      stg_rm  <= 8'(rmdist + {5'd0, rspd});
    end
  end

  // COMMIT: publish the whole register set at once
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      locx    <= INIT_X;
      locy    <= INIT_Y;
      botinfo <= 8'd0;
      sensors <= 8'd0;
      lmdist  <= 8'd0;
      rmdist  <= 8'd0;
    end else if (commit_c) begin
      locx    <= stg_x;
      locy    <= stg_y;
      botinfo <= {3'd0, stg_mov, stg_blk, stg_hdg};
      sensors <= {4'd0, (stg_y == 8'hFF), (stg_y == 8'h00),
                  (stg_x == 8'hFF), (stg_x == 8'h00)};
      lmdist  <= stg_lm;
      rmdist  <= stg_rm;
    end
  end

  // Update pulse, registered from the NOTIFY state
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      upd_sysregs <= 1'b0;
    end else begin
      upd_sysregs <= notify_c;
    end
  end

endmodule

// File: tb/tb_bot_sysreg_gen.sv
// Directed bench for bot_sysreg_gen with UPDATE_DIV=8: reset values, pulse
// timing, translation, rotation, saturation, odometer wrap, run hold and
// reset abort in NOTIFY.
module tb_bot_sysreg_gen;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] mot;
  logic [7:0] locx;
  logic [7:0] locy;
  logic [7:0] botinfo;
  logic [7:0] sensors;
  logic [7:0] lmdist;
  logic [7:0] rmdist;
  logic       upd;

  int n_cmp = 0;
  int n_err = 0;

  bot_sysreg_gen #(
    .UPDATE_DIV (8),
    .INIT_X     (8'd128),
    .INIT_Y     (8'd128)
  ) dut (
    .sysclk      (clk),
    .sysreset    (rst_n),
    .run         (run),
    .MotCtl      (mot),
    .locx        (locx),
    .locy        (locy),
    .botinfo     (botinfo),
    .sensors     (sensors),
    .lmdist      (lmdist),
    .rmdist      (rmdist),
    .upd_sysregs (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts rising edges until upd_sysregs is seen high at a falling edge
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!upd && n < 64);
    if (!upd) chk("pulse_timeout", 32'(upd), 32'd1);
  endtask

  task automatic updates(input int k, input logic [7:0] m);
    int n;
    mot = m;
    for (int i = 0; i < k; i++) wait_pulse(n);
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] bi, input logic [7:0] sn,
                          input logic [7:0] lm, input logic [7:0] rm);
    chk({tag, ".locx"},    32'(locx),    32'(x));
    chk({tag, ".locy"},    32'(locy),    32'(y));
    chk({tag, ".botinfo"}, 32'(botinfo), 32'(bi));
    chk({tag, ".sensors"}, 32'(sensors), 32'(sn));
    chk({tag, ".lmdist"},  32'(lmdist),  32'(lm));
    chk({tag, ".rmdist"},  32'(rmdist),  32'(rm));
  endtask

  initial begin
    int n;
    int seen;
    rst_n = 1'b0;
    run   = 1'b1;
    mot   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk_regs("reset", 8'd128, 8'd128, 8'h00, 8'h00, 8'd0, 8'd0);
    chk("reset.upd", 32'(upd), 32'd0);

    // First pulse DIV+3 edges after release, single cycle, then every DIV
    rst_n = 1'b1;
    wait_pulse(n);
    chk("first_pulse_lat", 32'(n), 32'd11);
    @(posedge clk);
    @(negedge clk);
    chk("pulse_width", 32'(upd), 32'd0);
    wait_pulse(n);
    chk("pulse_period", 32'(n + 1), 32'd8);
    chk_regs("idle", 8'd128, 8'd128, 8'h00, 8'h00, 8'd0, 8'd0);

    // Forward translate north
    updates(1, 8'h33);
    chk_regs("fwd_n", 8'd128, 8'd129, 8'h10, 8'h00, 8'd3, 8'd3);

    // Spin right 9 times, heading wraps 7->0
    mot = 8'h3B;
    for (int i = 0; i < 9; i++) begin
      wait_pulse(n);
      chk("spin.heading", 32'(botinfo), 32'((i + 1) % 8));
    end
    chk_regs("spin", 8'd128, 8'd129, 8'h01, 8'h00, 8'd30, 8'd30);

    // One more right turn to face east, then drive to x=255
    updates(1, 8'h3B);
    updates(127, 8'h11);
    chk_regs("east_edge", 8'd255, 8'd129, 8'h12, 8'h02, 8'd160, 8'd160);
    updates(1, 8'h11);
    chk_regs("east_block", 8'd255, 8'd129, 8'h0A, 8'h02, 8'd161, 8'd161);

    // Reverse drive moves west
    updates(1, 8'h99);
    chk_regs("reverse", 8'd254, 8'd129, 8'h12, 8'h00, 8'd162, 8'd162);

    // Single-wheel and counter-rotation turns
    updates(1, 8'h10);
    chk_regs("left_only", 8'd254, 8'd129, 8'h03, 8'h00, 8'd163, 8'd162);
    updates(1, 8'h01);
    chk_regs("right_only", 8'd254, 8'd129, 8'h02, 8'h00, 8'd163, 8'd163);
    updates(1, 8'hB3);
    chk_regs("lrev_rfwd", 8'd254, 8'd129, 8'h01, 8'h00, 8'd166, 8'd166);

    // Fresh reset, odometer wrap over 37 updates of speed 7
    @(negedge clk);
    rst_n = 1'b0;
    mot   = 8'h77;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    updates(37, 8'h77);
    chk_regs("odo_wrap", 8'd128, 8'd165, 8'h10, 8'h00, 8'd3, 8'd3);

    // Drive north into y=255
    updates(90, 8'h11);
    chk_regs("north_edge", 8'd128, 8'd255, 8'h10, 8'h08, 8'd93, 8'd93);
    updates(1, 8'h11);
    chk_regs("north_block", 8'd128, 8'd255, 8'h08, 8'h08, 8'd94, 8'd94);

    // Hold counter mid-period: no pulse while run=0, remaining 5 edges after
    mot = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    run  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (upd) seen++;
    end
    chk("hold.no_pulse", 32'(seen), 32'd0);
    run = 1'b1;
    wait_pulse(n);
    chk("hold.resume", 32'(n), 32'd5);

    // Reset while in NOTIFY aborts the pulse and restores reset values
    mot = 8'h33;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_regs("abort", 8'd128, 8'd128, 8'h00, 8'h00, 8'd0, 8'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (upd) seen++;
    end
    chk("abort.no_pulse", 32'(seen), 32'd0);
    rst_n = 1'b1;
    wait_pulse(n);
    chk("abort.relatency", 32'(n), 32'd11);
    chk_regs("abort.after", 8'd128, 8'd129, 8'h10, 8'h00, 8'd3, 8'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
